alu_op_sequencer: RTL and testbench

- Command-driven controller that sequences one 20-bit ALU operation at a time: add/sub/logic/shift/increment/pass.
- Also runs an iterative shift-add multiply over 20 cycles on the same adder and shift datapath.
- Upstream uses a valid/ready command handshake. Downstream receives a valid/ready result handshake carrying the result and its flags.
- Sits between the instruction/control layer and the word-level ALU components; owns the carry flag used by add-with-carry.

---
 rtl/alu_op_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Command-driven sequencer for one 20-bit ALU operation at a time, including an
// iterative shift-add multiply; valid/ready on both command and result sides.
module alu_op_sequencer #(
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_carry,
    output logic             res_ovf,
    output logic             res_err,
    output logic             busy
);

    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned SUM_W = WIDTH + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_INC  = 4'd9;
    localparam logic [3:0] OP_PASS = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_flag;

    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH-1:0]   exec_data;
    logic               exec_carry;
    logic               exec_err;
    logic               exec_upd_carry;
    logic [SUM_W-1:0]   exec_sum;
    logic [ACC_W-1:0]   mul_next;
    logic               mul_last;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/status decode
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        unique case (state)
            S_IDLE: begin
                busy      = 1'b0;
                cmd_ready = ~reset;
                if (cmd_valid) begin
                    state_next = (cmd_op == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: state_next = S_DONE;
            S_MUL: begin
                if (mul_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Single-cycle ALU result for the EXEC state
    always_comb begin
        exec_data      = '0;
        exec_carry     = 1'b0;
        exec_err       = 1'b0;
        exec_upd_carry = 1'b0;
        exec_sum       = '0;
        case (op_q)
            OP_ADD: begin
                exec_sum       = {1'b0, a_q} + {1'b0, b_q};
                exec_data      = exec_sum[WIDTH-1:0];
                exec_carry     = exec_sum[WIDTH];
                exec_upd_carry = 1'b1;
            end
            OP_ADDC: begin
                exec_sum       = {1'b0, a_q} + {1'b0, b_q} + SUM_W'(carry_flag);
                exec_data      = exec_sum[WIDTH-1:0];
                exec_carry     = exec_sum[WIDTH];
                exec_upd_carry = 1'b1;
            end
            OP_SUB: begin
                exec_data      = a_q - b_q;
                exec_carry     = (a_q < b_q);
                exec_upd_carry = 1'b1;
            end
            OP_AND:  exec_data = a_q & b_q;
            OP_OR:   exec_data = a_q | b_q;
            OP_XOR:  exec_data = a_q ^ b_q;
            OP_NOT:  exec_data = ~a_q;
            OP_SHL:  exec_data = a_q << b_q[3:0];
            OP_SHR:  exec_data = a_q >> b_q[3:0];
            OP_INC:  exec_data = a_q + WIDTH'(1);
            OP_PASS: exec_data = b_q;
            OP_MUL:  exec_data = '0;
            default: exec_err  = 1'b1;
        endcase
    end

    // One multiplier bit per cycle, LSB first
    assign mul_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));

    // Operand capture, multiply iteration and registered result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            carry_flag <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_zero   <= 1'b0;
            res_carry  <= 1'b0;
            res_ovf    <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        a_q      <= cmd_a;
                        b_q      <= cmd_b;
                        acc_q    <= '0;
                        mcand_q  <= ACC_W'(cmd_a);
                        mplier_q <= cmd_b;
                        cnt_q    <= '0;
                    end
                end
                S_EXEC: begin
                    res_valid <= 1'b1;
                    res_data  <= exec_data;
                    res_zero  <= ~|exec_data;
                    res_carry <= exec_carry;
                    res_ovf   <= 1'b0;
                    res_err   <= exec_err;
                    if (exec_upd_carry) begin
                        carry_flag <= exec_carry;
                    end
                end
                S_MUL: begin
                    acc_q    <= mul_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (mul_last) begin
                        res_valid <= 1'b1;
                        res_data  <= mul_next[WIDTH-1:0];
                        res_zero  <= ~|mul_next[WIDTH-1:0];
                        res_carry <= 1'b0;
                        res_ovf   <= |mul_next[ACC_W-1:WIDTH];
                        res_err   <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_data  <= '0;
                        res_zero  <= 1'b0;
                        res_carry <= 1'b0;
                        res_ovf   <= 1'b0;
                        res_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vector table, multi-cycle corner sequences
// and randomized commands checked against an arithmetic reference model.
module tb_alu_op_sequencer;

    localparam int unsigned W = 20;
    localparam longint unsigned MOD = 64'd1 << W;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic          res_zero;
    logic          res_carry;
    logic          res_ovf;
    logic          res_err;
    logic          busy;

    alu_op_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_carry (res_carry),
        .res_ovf   (res_ovf),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         z;
        logic         c;
        logic         v;
        logic         e;
        int           lat;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic model_cf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain wide arithmetic on the opcode definitions
    function automatic vec_t ref_op(input logic [3:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic cf);
        vec_t v;
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint unsigned r  = 0;
        int sh = int'(b) % 16;
        v.op = op; v.a = a; v.b = b;
        v.c = 1'b0; v.v = 1'b0; v.e = 1'b0;
        v.lat = (op == 4'd11) ? 21 : 2;
        case (int'(op))
            0:  begin r = ua + ub;               v.c = (r >= MOD); end
            1:  begin r = ua + ub + 64'(cf);     v.c = (r >= MOD); end
            2:  begin r = ua + MOD - ub;         v.c = (ua < ub);  end
            3:  r = ua & ub;
            4:  r = ua | ub;
            5:  r = ua ^ ub;
            6:  r = (MOD - 1) - ua;
            7:  r = ua * (64'd1 << sh);
            8:  r = ua / (64'd1 << sh);
            9:  r = ua + 1;
            10: r = ub;
            11: begin r = ua * ub;               v.v = (r >= MOD); end
            default: begin r = 0;                v.e = 1'b1; end
        endcase
        v.d = W'(r % MOD);
        v.z = (v.d == '0);
        return v;
    endfunction

    // Issue one command, wait for its result, check it, optionally stall, then accept it
    task automatic do_op(input vec_t v, input string name, input int stall, input bit hold_cmd);
        int lat = 0;
        @(negedge clk);
        chk({name, "_idle_valid"}, 32'(res_valid), 32'd0);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b;
        #1;
        chk({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_a = W'($urandom); cmd_b = W'($urandom);
        do begin
            @(negedge clk);
            lat++;
            chk({name, "_busy"}, 32'(busy), 32'd1);
        end while (!res_valid && lat < 60);
        chk({name, "_latency"}, 32'(lat), 32'(v.lat));
        chk({name, "_data"},  32'(res_data),  32'(v.d));
        chk({name, "_zero"},  32'(res_zero),  32'(v.z));
        chk({name, "_carry"}, 32'(res_carry), 32'(v.c));
        chk({name, "_ovf"},   32'(res_ovf),   32'(v.v));
        chk({name, "_err"},   32'(res_err),   32'(v.e));
        chk({name, "_done_ready"}, 32'(cmd_ready), 32'd0);
        if (hold_cmd) begin
            cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = W'(1); cmd_b = W'(1);
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({name, "_hold_valid"}, 32'(res_valid), 32'd1);
            chk({name, "_hold_data"},  32'(res_data),  32'(v.d));
            chk({name, "_hold_flags"}, 32'({res_zero, res_carry, res_ovf, res_err}),
                32'({v.z, v.c, v.v, v.e}));
            chk({name, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        if (v.op <= 4'd2) model_cf = v.c;
    endtask

    vec_t tbl[$];
    vec_t rv;

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] d, input logic z, input logic c,
                                input logic ov, input logic e);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.d = d; v.z = z; v.c = c; v.v = ov; v.e = e;
        v.lat = (op == 4'd11) ? 21 : 2;
        return v;
    endfunction

    initial begin
        // Directed vectors with hand-derived expectations
        tbl.push_back(mk(4'd0,  20'hFFFFF, 20'h00001, 20'h00000, 1, 1, 0, 0));
        tbl.push_back(mk(4'd1,  20'h00000, 20'h00000, 20'h00001, 0, 0, 0, 0));
        tbl.push_back(mk(4'd2,  20'h00005, 20'h00007, 20'hFFFFE, 0, 1, 0, 0));
        tbl.push_back(mk(4'd3,  20'hF0F0F, 20'h0FFFF, 20'h00F0F, 0, 0, 0, 0));
        tbl.push_back(mk(4'd1,  20'h00000, 20'h00000, 20'h00001, 0, 0, 0, 0));
        tbl.push_back(mk(4'd11, 20'h00123, 20'h00010, 20'h01230, 0, 0, 0, 0));
        tbl.push_back(mk(4'd11, 20'h80000, 20'h00002, 20'h00000, 1, 0, 1, 0));
        tbl.push_back(mk(4'd7,  20'h00001, 20'h0000F, 20'h08000, 0, 0, 0, 0));
        tbl.push_back(mk(4'd4,  20'hA0000, 20'h0000A, 20'hA000A, 0, 0, 0, 0));
        tbl.push_back(mk(4'd5,  20'hFFFFF, 20'h0F0F0, 20'hF0F0F, 0, 0, 0, 0));
        tbl.push_back(mk(4'd6,  20'hFFFFF, 20'h12345, 20'h00000, 1, 0, 0, 0));
        tbl.push_back(mk(4'd10, 20'h11111, 20'h54321, 20'h54321, 0, 0, 0, 0));
        tbl.push_back(mk(4'd13, 20'h12345, 20'h00000, 20'h00000, 1, 0, 0, 1));
        tbl.push_back(mk(4'd9,  20'hFFFFF, 20'h00000, 20'h00000, 1, 0, 0, 0));

        // Reset with a command pending: reset wins
        reset = 1'b1; cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_outputs", 32'({res_valid, busy, res_zero, res_carry, res_ovf, res_err}), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        model_cf = 1'b0;

        foreach (tbl[i]) do_op(tbl[i], $sformatf("vec%0d", i), 0, 1'b0);

        // Back-pressure: SHR held for 5 cycles while a command waits upstream
        do_op(mk(4'd8, 20'h80000, 20'h00004, 20'h08000, 0, 0, 0, 0), "shr_bp", 5, 1'b1);
        @(negedge clk);
        chk("bp_idle_ready", 32'(cmd_ready), 32'd1);

        // Reset in MUL cycle 10 with carry_flag set beforehand
        do_op(mk(4'd0, 20'hFFFFF, 20'h00002, 20'h00001, 0, 1, 0, 0), "pre_mul_add", 0, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd11; cmd_a = 20'h00003; cmd_b = 20'h00005;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_mul_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mul_rst_state", 32'({res_valid, busy, res_zero}), 32'd0);
        chk("mul_rst_ready", 32'(cmd_ready), 32'd1);
        model_cf = 1'b0;
        do_op(mk(4'd1, 20'h00000, 20'h00000, 20'h00000, 1, 0, 0, 0), "addc_after_rst", 0, 1'b0);
        do_op(mk(4'd0, 20'h00001, 20'h00001, 20'h00002, 0, 0, 0, 0), "add_after_rst", 0, 1'b0);

        // Randomized commands against the reference model
        for (int k = 0; k < 150; k++) begin
            logic [3:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       a = '1;
                1:       a = '0;
                default: a = W'($urandom);
            endcase
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            rv = ref_op(op, a, b, model_cf);
            do_op(rv, $sformatf("rnd%0d_op%0d", k, op), int'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
